// File: rtl/perf_monitor_pkg.sv
// Shared types for the performance monitor: FSM states, counter-select codes
// and event type encodings.
package perf_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] CNT_CYC   = 2'd0;
    localparam logic [1:0] CNT_STALL = 2'd1;
    localparam logic [1:0] CNT_FLUSH = 2'd2;
    localparam logic [1:0] CNT_RET   = 2'd3;

    // Event type is {stall, flush}
    localparam int unsigned EVT_TYPE_W = 2;
    localparam logic [1:0] EVT_NONE  = 2'b00;
    localparam logic [1:0] EVT_FLUSH = 2'b01;
    localparam logic [1:0] EVT_STALL = 2'b10;
    localparam logic [1:0] EVT_BOTH  = 2'b11;

endpackage

// File: rtl/perf_monitor_evt_fifo.sv
// First-word-fall-through event FIFO; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module evt_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_q, rd_q, wr_d, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty, wr_en, rd_en;

    assign empty  = (wr_q == rd_q);
    assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rd_en  = pop_i && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge
    assign wr_en  = push_i && (!full_o || rd_en);
    assign wr_d   = wr_q + PW'(wr_en);
    assign rd_d   = rd_q + PW'(rd_en);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clr_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: saturating cycle/stall/flush/retire counters
// gated by a run FSM, plus a stall/flush event log drained through a FIFO.
module perf_monitor
    import perf_monitor_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned EVT_DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           stall_i,
    input  logic                           flush_i,
    input  logic                           retire_i,
    input  logic [PC_W-1:0]                pc_i,
    input  logic [CNT_W-1:0]               limit_i,
    input  logic [1:0]                     sel_i,
    output logic [CNT_W-1:0]               cnt_o,
    output logic                           done_o,
    output logic                           evt_valid_o,
    input  logic                           evt_ready_i,
    output logic [EVT_TYPE_W+CNT_W+PC_W-1:0] evt_data_o,
    output logic                           evt_ovf_o
);

    localparam int unsigned EVT_W = EVT_TYPE_W + CNT_W + PC_W;

    state_e           state_q;
    logic [CNT_W-1:0] cyc_q, stall_q, flush_q, ret_q, limit_q;
    logic [CNT_W-1:0] cyc_d;
    logic             done_q, ovf_q;
    logic             running, limit_hit;
    logic             evt_push, evt_pop, evt_drop, fifo_full, fifo_valid, fifo_clr;
    logic [1:0]       evt_type;
    logic [EVT_W-1:0] evt_wdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign running   = (state_q == ST_RUN);
    assign cyc_d     = sat_inc(cyc_q);
    assign limit_hit = (limit_q != '0) && (cyc_d == limit_q);

    // Events are stamped with the cycle count before this cycle's increment
    assign evt_type  = {stall_i, flush_i};
    assign evt_push  = running && (evt_type != EVT_NONE);
    assign evt_pop   = fifo_valid && evt_ready_i;
    assign evt_drop  = evt_push && fifo_full && !evt_pop;
    assign fifo_clr  = (state_q == ST_IDLE) && start_i;
    assign evt_wdata = {evt_type, cyc_q, pc_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            limit_q <= '0;
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
            ret_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        ovf_q   <= 1'b0;
                        limit_q <= limit_i;
                        cyc_q   <= '0;
                        stall_q <= '0;
                        flush_q <= '0;
                        ret_q   <= '0;
                    end
                end
                ST_RUN: begin
                    cyc_q <= cyc_d;
                    if (stall_i)  stall_q <= sat_inc(stall_q);
                    if (flush_i)  flush_q <= sat_inc(flush_q);
                    if (retire_i) ret_q   <= sat_inc(ret_q);
                    if (evt_drop) ovf_q   <= 1'b1;
                    if (!start_i || limit_hit) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Holding start high keeps DONE; a re-run needs start to drop
                    if (!start_i) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_o = cyc_q;
        case (sel_i)
            CNT_CYC:   cnt_o = cyc_q;
            CNT_STALL: cnt_o = stall_q;
            CNT_FLUSH: cnt_o = flush_q;
            CNT_RET:   cnt_o = ret_q;
            default:   cnt_o = cyc_q;
        endcase
    end

    evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (EVT_DEPTH)
    ) u_evt_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (fifo_clr),
        .push_i  (evt_push),
        .pop_i   (evt_pop),
        .data_i  (evt_wdata),
        .data_o  (evt_data_o),
        .valid_o (fifo_valid),
        .full_o  (fifo_full)
    );

    assign evt_valid_o = fifo_valid;
    assign done_o      = done_q;
    assign evt_ovf_o   = ovf_q;

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of every counter and of the cycle timestamp.
REQ-002 The block SHALL have parameter PC_W, default 32, giving the width of the sampled PC.
REQ-003 The block SHALL have parameter EVT_DEPTH, default 8, giving the event FIFO depth; it must be a power of two and at least 2.
REQ-004 Port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 Port start_i, input, 1: run request, level-sensitive.
REQ-007 Port stall_i, input, 1: pipeline stall this cycle.
REQ-008 Port flush_i, input, 1: pipeline flush this cycle.
REQ-009 Port retire_i, input, 1: one instruction retired this cycle.
REQ-010 Port pc_i, input, PC_W: current fetch PC.
REQ-011 Port limit_i, input, CNT_W: cycle limit; 0 = unlimited; sampled only on the IDLE->RUN transition.
REQ-012 Port sel_i, input, 2: counter select (0 cycles, 1 stalls, 2 flushes, 3 retired).
REQ-013 Port cnt_o, output, CNT_W: the selected counter value.
REQ-014 Port done_o, output, 1: high in state DONE.
REQ-015 Port evt_valid_o, output, 1: the event FIFO is non-empty.
REQ-016 Port evt_ready_i, input, 1: consumer accepts the head event.
REQ-017 Port evt_data_o, output, 2+CNT_W+PC_W: {type[1:0] = {stall, flush}, cycle, pc}.
REQ-018 Port evt_ovf_o, output, 1: sticky flag, set when an event was dropped.

Function
REQ-019 The FSM SHALL have states IDLE, RUN and DONE.
REQ-020 IDLE->RUN SHALL occur when start_i=1; on that edge all four counters, the FIFO and evt_ovf_o clear, and limit_i is latched.
REQ-021 RUN->DONE SHALL occur when start_i=0, or when the latched limit is non-zero and the cycle counter would reach it this cycle.
REQ-022 DONE->IDLE SHALL occur when start_i=0; DONE with start_i=1 SHALL hold state, so a re-run requires start_i to drop first.
REQ-023 In RUN each cycle, the cycle counter SHALL increment by 1; the stall, flush and retired counters SHALL each increment when their input is 1.
REQ-024 Every counter SHALL saturate at all-ones and never wrap.
REQ-025 Counters SHALL be frozen in IDLE and DONE; their values remain readable via cnt_o.
REQ-026 Counter updates SHALL be visible on cnt_o one cycle after the sampled input; cnt_o is a combinational mux of the registered counters.
REQ-027 In RUN, a cycle with stall_i or flush_i high SHALL push exactly one event.
REQ-028 The pushed event SHALL carry type {stall_i, flush_i}, the pre-increment cycle count and pc_i; stall and flush together give one event of type 2'b11.
REQ-029 The FIFO SHALL be first-word-fall-through: evt_data_o is the head entry whenever evt_valid_o=1.
REQ-030 A pop SHALL occur when evt_valid_o and evt_ready_i are both 1.
REQ-031 When the FIFO is full, a push SHALL be accepted only if a pop occurs in the same cycle; otherwise the event is dropped and evt_ovf_o is set.
REQ-032 Draining SHALL continue in IDLE and DONE; no pushes occur outside RUN.
REQ-033 Simultaneous push and pop on an empty FIFO SHALL store the new event; it becomes visible on the next cycle.

Reset
REQ-034 While rst_i is high, the state SHALL be IDLE, all counters 0, the FIFO empty and the latched limit 0.
REQ-035 While rst_i is high, outputs SHALL be cnt_o=0, done_o=0, evt_valid_o=0, evt_ovf_o=0 and evt_data_o=0.
REQ-036 Reset asserted mid-RUN SHALL abort immediately; no partial event is retained.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the counter-select codes (CNT_CYC, CNT_STALL, CNT_FLUSH, CNT_RET) and the event type codes.
REQ-038 Sub-module evt_fifo SHALL be parametrised by width and depth, with its own pointers and an extra wrap bit for full/empty detection.

Verification
REQ-039 Bench SHALL cover: limit_i=30, start_i held 1 -> done_o rises after exactly 30 RUN cycles; sel_i=0 reads 30.
REQ-040 Bench SHALL cover: stall_i pulsed on RUN cycles 3 and 7, flush_i on cycle 7 -> stall count 2, flush count 1; two events, types 2'b10 at cycle 3 and 2'b11 at cycle 7, each with the matching pc_i.
REQ-041 Bench SHALL cover: evt_ready_i=0, 10 stall cycles with EVT_DEPTH=8 -> 8 events held, evt_ovf_o=1, then drains in order of cycle stamps.
REQ-042 Bench SHALL cover: CNT_W=4, limit_i=0, 20 RUN cycles -> cycle counter saturates at 15.
REQ-043 Bench SHALL cover: start_i dropped then raised after DONE -> counters clear and evt_ovf_o clears on the re-entry to RUN.
REQ-044 Bench SHALL cover: rst_i asserted mid-RUN with 3 events queued -> same-edge IDLE, evt_valid_o=0, all counters 0.
